img_rom_scan_ctrl: RTL and testbench

Raster controller that sequences reads of the 64K×24 single-port picture ROM, which holds a 256×256 RGB888 image, against the HDMI video timing stream. It places the image in a programmable window of the active area and issues ROM addresses. It re-aligns HSYNC, VSYNC and DE with the ROM data, then outputs the pixel as original color, grayscale, or thresholded binary (plain or inverted). It sits between the video timing generator and the HDMI encoder in the picture-binarization design.

---
 rtl/img_rom_scan_ctrl.sv | 114 +++++++++++
 tb/tb_img_rom_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/img_rom_scan_ctrl.sv
// img_rom_scan_ctrl: windowed raster reads of a picture ROM, timing realignment and color/gray/binary output.
module img_rom_scan_ctrl #(
    parameter int          IMG_W_LOG2 = 8,
    parameter int          IMG_H_LOG2 = 8,
    parameter int          ADDR_WIDTH = IMG_W_LOG2 + IMG_H_LOG2,
    parameter int          DATA_WIDTH = 24,
    parameter int          CNT_WIDTH  = 12,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vs_i,
    input  logic                  hs_i,
    input  logic                  de_i,
    input  logic [CNT_WIDTH-1:0]  x_ofs,
    input  logic [CNT_WIDTH-1:0]  y_ofs,
    input  logic [1:0]            mode,
    input  logic [7:0]            thr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  vs_o,
    output logic                  hs_o,
    output logic                  de_o,
    output logic [23:0]           rgb_o
);
    localparam int CW = CNT_WIDTH + 1;

    logic                  vs_d, de_d, frame_start, in_win, bin;
    logic [CNT_WIDTH-1:0]  x_cnt, y_cnt, x_ofs_s, y_ofs_s;
    logic [1:0]            mode_s;
    logic [7:0]            thr_s, gray3;
    logic [CW-1:0]         x_lim, y_lim;
    logic [IMG_W_LOG2-1:0] x_rel;
    logic [IMG_H_LOG2-1:0] y_rel;
    logic [2:0]            tim1, tim2, tim3;
    logic                  win1, win2, win3;
    logic [DATA_WIDTH-1:0] rgb3;
    logic [15:0]           gray_sum;
    logic [23:0]           pix, rgb_next;

    // window limits are one bit wider than the counters so a window past counter range never wraps
    always_comb begin
        frame_start = vs_i & ~vs_d;
        x_lim       = {1'b0, x_ofs_s} + CW'(2 ** IMG_W_LOG2);
        y_lim       = {1'b0, y_ofs_s} + CW'(2 ** IMG_H_LOG2);
        in_win      = de_i && x_cnt >= x_ofs_s && {1'b0, x_cnt} < x_lim
                           && y_cnt >= y_ofs_s && {1'b0, y_cnt} < y_lim;
        x_rel       = x_cnt[IMG_W_LOG2-1:0] - x_ofs_s[IMG_W_LOG2-1:0];
        y_rel       = y_cnt[IMG_H_LOG2-1:0] - y_ofs_s[IMG_H_LOG2-1:0];
        gray_sum    = 16'd77 * 16'(rom_rd_data[23:16]) + 16'd150 * 16'(rom_rd_data[15:8])
                    + 16'd29 * 16'(rom_rd_data[7:0]);
        bin         = (gray3 >= thr_s) ^ mode_s[0];
        pix         = mode_s == 2'b00 ? rgb3[23:0] : mode_s == 2'b01 ? {3{gray3}} : {24{bin}};
        rgb_next    = !tim3[0] ? 24'h000000 : win3 ? pix : BG_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d     <= 1'b0;
            de_d     <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            x_ofs_s  <= '0;
            y_ofs_s  <= '0;
            mode_s   <= 2'b00;
            thr_s    <= 8'd0;
            rom_addr <= '0;
        end else begin
            vs_d  <= vs_i;
            de_d  <= de_i;
            x_cnt <= de_i ? x_cnt + CNT_WIDTH'(1) : '0;
            if (frame_start) begin
                y_cnt   <= '0;
                x_ofs_s <= x_ofs;
                y_ofs_s <= y_ofs;
                mode_s  <= mode;
                thr_s   <= thr;
            end else if (de_d && !de_i) begin
                y_cnt <= y_cnt + CNT_WIDTH'(1);
            end
            if (in_win)
                rom_addr <= ADDR_WIDTH'({y_rel, x_rel});
        end
    end

    // stage 1: address issued; stage 2: ROM access; stage 3: gray; stage 4: output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim1  <= 3'b000;
            tim2  <= 3'b000;
            tim3  <= 3'b000;
            win1  <= 1'b0;
            win2  <= 1'b0;
            win3  <= 1'b0;
            rgb3  <= '0;
            gray3 <= 8'd0;
            vs_o  <= 1'b0;
            hs_o  <= 1'b0;
            de_o  <= 1'b0;
            rgb_o <= 24'h000000;
        end else begin
            tim1  <= {vs_i, hs_i, de_i};
            tim2  <= tim1;
            tim3  <= tim2;
            win1  <= in_win;
            win2  <= win1;
            win3  <= win2;
            rgb3  <= rom_rd_data;
            gray3 <= 8'(gray_sum >> 8);
            {vs_o, hs_o, de_o} <= tim3;
            rgb_o <= rgb_next;
        end
    end
endmodule

// File: tb/tb_img_rom_scan_ctrl.sv
// tb_img_rom_scan_ctrl: scoreboard bench driving small raster frames against a pixel-level reference model.
module tb_img_rom_scan_ctrl;
    typedef struct {
        int          t;
        logic        vs, hs, de;
        logic [23:0] rgb;
    } exp_t;
    typedef struct {
        int          t;
        logic [15:0] a;
    } addr_t;

    logic        clk = 1'b0, rst_n = 1'b0, vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
    logic [11:0] x_ofs = '0, y_ofs = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  thr = '0;
    logic [15:0] rom_addr;
    logic [23:0] rom_rd_data = '0;
    logic        vs_o, hs_o, de_o;
    logic [23:0] rgb_o;

    int          cyc = 0, n_vec = 0, n_bad = 0;
    int          rom_kind = 0;
    logic [23:0] rom_const = '0;
    int          sx = 0, sy = 0, sm = 0, st = 0, row = 0;
    logic        vs_prev = 1'b0, rn_cur = 1'b0;
    logic [15:0] a_exp = '0;
    exp_t        exp_q[$];
    addr_t       addr_q[$];

    img_rom_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
        .x_ofs(x_ofs), .y_ofs(y_ofs), .mode(mode), .thr(thr),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .rgb_o(rgb_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] rom_word(input logic [15:0] a);
        logic [7:0] hi, lo;
        hi = a[15:8];
        lo = a[7:0];
        if (rom_kind == 0) return {8'h00, a};
        if (rom_kind == 1) return rom_const;
        return {hi + lo, lo ^ 8'h5A, hi * 8'd3};
    endfunction

    always @(posedge clk) rom_rd_data <= rom_word(rom_addr);

    function automatic logic [23:0] pix_ref(input logic [23:0] w, input int m, input int t);
        int g;
        logic [7:0] g8;
        g  = (77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0])) / 256;
        g8 = 8'(g);
        if (m == 0) return w;
        if (m == 1) return {g8, g8, g8};
        return ((g >= t) == (m == 2)) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic tick(input logic v, input logic h, input logic d, input int col);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn_cur;
        vs_i  = v;
        hs_i  = h;
        de_i  = d;
        e = '{cyc, v, h, d, 24'h000000};
        if (!rn_cur) begin
            sx = 0; sy = 0; sm = 0; st = 0; row = 0;
            vs_prev = 1'b0;
            a_exp = '0;
            e.vs = 1'b0; e.hs = 1'b0; e.de = 1'b0;
        end else begin
            if (v && !vs_prev) begin
                sx = int'(x_ofs); sy = int'(y_ofs); sm = int'(mode); st = int'(thr);
                row = 0;
            end
            vs_prev = v;
            if (d && col >= sx && col < sx + 256 && row >= sy && row < sy + 256) begin
                a_exp = 16'(((row - sy) % 256) * 256 + (col - sx) % 256);
                e.rgb = pix_ref(rom_word(a_exp), sm, st);
            end
        end
        exp_q.push_back(e);
        addr_q.push_back('{cyc, a_exp});
    endtask

    task automatic kill_pipe();
        foreach (exp_q[i]) begin
            exp_q[i].vs = 1'b0; exp_q[i].hs = 1'b0; exp_q[i].de = 1'b0; exp_q[i].rgb = '0;
        end
        foreach (addr_q[i]) addr_q[i].a = '0;
        a_exp = '0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        rn_cur = 1'b0;
        kill_pipe();
        #1;
        n_vec++;
        if ({rom_addr, vs_o, hs_o, de_o, rgb_o} !== '0) begin
            n_bad++;
            $display("FAIL async_reset got addr=%h vs=%b hs=%b de=%b rgb=%h want all 0",
                     rom_addr, vs_o, hs_o, de_o, rgb_o);
        end
    endtask

    task automatic line(input int ha, input int rst_at);
        repeat (2) tick(1'b0, 1'b1, 1'b0, 0);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 0);
        for (int c = 0; c < ha; c++) begin
            if (c == rst_at) async_reset();
            tick(1'b0, 1'b0, 1'b1, c);
        end
        row++;
        if (!rn_cur) begin
            repeat (2) tick(1'b0, 1'b0, 1'b0, 0);
            rn_cur = 1'b1;
        end
        repeat (4) tick(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic frame(input int ha, input int va, input int xo, input int yo,
                         input int m, input int t, input bit scr, input int rst_line);
        x_ofs = 12'(xo); y_ofs = 12'(yo); mode = 2'(m); thr = 8'(t);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 0);
        for (int ln = 0; ln < va; ln++) begin
            if (scr) begin
                x_ofs = 12'($urandom); y_ofs = 12'($urandom);
                mode = 2'($urandom); thr = 8'($urandom);
            end
            line(ha, ln == rst_line ? ha / 2 : -1);
        end
        repeat (8) tick(1'b0, 1'b0, 1'b0, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        addr_t ae;
        if (addr_q.size() > 0 && addr_q[0].t + 1 == cyc) begin
            ae = addr_q.pop_front();
            n_vec++;
            if (rom_addr !== ae.a) begin
                n_bad++;
                $display("FAIL rom_addr issue_cyc=%0d got %h want %h", ae.t, rom_addr, ae.a);
            end
        end
        if (exp_q.size() > 0 && exp_q[0].t + 4 == cyc) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({vs_o, hs_o, de_o, rgb_o} !== {e.vs, e.hs, e.de, e.rgb}) begin
                n_bad++;
                $display("FAIL pixel issue_cyc=%0d got vs=%b hs=%b de=%b rgb=%h want vs=%b hs=%b de=%b rgb=%h",
                         e.t, vs_o, hs_o, de_o, rgb_o, e.vs, e.hs, e.de, e.rgb);
            end
        end
    end

    initial begin
        rn_cur = 1'b0;
        repeat (20) tick(1'($urandom), 1'($urandom), 1'($urandom), 0);
        rn_cur = 1'b1;
        repeat (5) tick(1'b0, 1'b0, 1'b0, 0);
        rom_kind = 0;
        frame(264, 6, 0, 0, 0, 0, 1'b0, -1);
        frame(4000, 2, 3900, 0, 0, 0, 1'b0, -1);
        rom_kind = 2;
        frame(8, 264, 2, 5, 1, 0, 1'b0, -1);
        rom_kind = 1;
        rom_const = 24'h808080;
        frame(16, 4, 0, 0, 2, 128, 1'b1, -1);
        frame(16, 4, 0, 0, 2, 129, 1'b1, -1);
        frame(16, 4, 0, 0, 3, 129, 1'b0, -1);
        rom_const = 24'hFF0000;
        frame(16, 4, 0, 0, 1, 0, 1'b0, -1);
        rom_kind = 0;
        frame(40, 6, 3, 1, 2, 100, 1'b0, 2);
        frame(40, 4, 3, 1, 2, 100, 1'b0, -1);
        repeat (10) begin
            rom_kind  = int'($urandom_range(0, 2));
            rom_const = 24'($urandom);
            frame(int'($urandom_range(8, 300)), int'($urandom_range(3, 8)),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1, -1);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d/%0d pending want 0/0", exp_q.size(), addr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
